// File: rtl/hpdcache_victim_ctrl.sv
// Refill victim controller: reads the directory for a set, asks the replacement
// policy for a victim way, writes back a dirty victim, then responds and updates.
module hpdcache_victim_ctrl #(
  parameter int unsigned SETS = 64,
  parameter int unsigned WAYS = 4,
  localparam int unsigned S = $clog2(SETS)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [S-1:0]    req_set_i,
  output logic            dir_rd_o,
  output logic [S-1:0]    dir_rd_set_o,
  input  logic [WAYS-1:0] dir_valid_i,
  input  logic [WAYS-1:0] dir_wback_i,
  input  logic [WAYS-1:0] dir_dirty_i,
  input  logic [WAYS-1:0] dir_fetch_i,
  output logic            sel_victim_o,
  output logic [S-1:0]    sel_victim_set_o,
  output logic [WAYS-1:0] sel_dir_valid_o,
  output logic [WAYS-1:0] sel_dir_wback_o,
  output logic [WAYS-1:0] sel_dir_dirty_o,
  output logic [WAYS-1:0] sel_dir_fetch_o,
  input  logic [WAYS-1:0] sel_victim_way_i,
  output logic            updt_o,
  output logic [S-1:0]    updt_set_o,
  output logic [WAYS-1:0] updt_way_o,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [S-1:0]    wb_set_o,
  output logic [WAYS-1:0] wb_way_o,
  output logic            rsp_valid_o,
  output logic [S-1:0]    rsp_set_o,
  output logic [WAYS-1:0] rsp_way_o,
  output logic [7:0]      retry_cnt_o
);

  typedef enum logic [2:0] {IDLE, DIR_RD, SELECT, WBACK, RESP} state_e;

  state_e          state_q, state_d;
  logic [S-1:0]    set_q, set_d;
  logic [WAYS-1:0] way_q, way_d;
  logic            dirty_q, dirty_d;
  logic [7:0]      retry_q, retry_d;

  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    way_d   = way_q;
    dirty_d = dirty_q;
    retry_d = retry_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          set_d   = req_set_i;
          state_d = DIR_RD;
        end
      end
      DIR_RD: state_d = SELECT;
      SELECT: begin
        // No way available: re-read the directory, since its state may have moved on.
        if (sel_victim_way_i == '0) begin
          state_d = DIR_RD;
          if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
        end else begin
          way_d   = sel_victim_way_i;
          dirty_d = |(sel_victim_way_i & dir_valid_i & dir_dirty_i);
          state_d = dirty_d ? WBACK : RESP;
        end
      end
      WBACK: begin
        if (wb_ready_i) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      set_q   <= '0;
      way_q   <= '0;
      dirty_q <= 1'b0;
      retry_q <= 8'd0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      way_q   <= way_d;
      dirty_q <= dirty_d;
      retry_q <= retry_d;
    end
  end

  // Every output is decoded from registered state; data is zeroed outside its strobe.
  assign req_ready_o      = (state_q == IDLE);
  assign dir_rd_o         = (state_q == DIR_RD);
  assign dir_rd_set_o     = dir_rd_o ? set_q : '0;
  assign sel_victim_o     = (state_q == SELECT);
  assign sel_victim_set_o = sel_victim_o ? set_q : '0;
  assign sel_dir_valid_o  = sel_victim_o ? dir_valid_i : '0;
  assign sel_dir_wback_o  = sel_victim_o ? dir_wback_i : '0;
  assign sel_dir_dirty_o  = sel_victim_o ? dir_dirty_i : '0;
  assign sel_dir_fetch_o  = sel_victim_o ? dir_fetch_i : '0;
  assign wb_valid_o       = (state_q == WBACK);
  assign wb_set_o         = wb_valid_o ? set_q : '0;
  assign wb_way_o         = wb_valid_o ? way_q : '0;
  assign rsp_valid_o      = (state_q == RESP);
  assign rsp_set_o        = rsp_valid_o ? set_q : '0;
  assign rsp_way_o        = rsp_valid_o ? way_q : '0;
  assign updt_o           = rsp_valid_o;
  assign updt_set_o       = rsp_set_o;
  assign updt_way_o       = rsp_way_o;
  assign retry_cnt_o      = retry_q;

endmodule

// File: doc/hpdcache_victim_ctrl.md
HPDCACHE_VICTIM_CTRL -- requirements
Module: hpdcache_victim_ctrl

Interface
REQ-001 SHALL have parameter SETS, default 64, number of cache sets (power of 2, >=2).
REQ-002 SHALL have parameter WAYS, default 4, number of cache ways (>=2).
REQ-003 SHALL have the following ports; S = $clog2(SETS), W = WAYS:
- clk_i  in  1  the only clock; all state samples on its rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  refill victim request valid.
- req_ready_o  out  1  request accepted when high together with req_valid_i.
- req_set_i  in  S  set of the request.
- dir_rd_o  out  1  directory read strobe.
- dir_rd_set_o  out  S  directory read set.
- dir_valid_i, dir_wback_i, dir_dirty_i, dir_fetch_i  in  W each  directory state, valid the cycle after dir_rd_o.
- sel_victim_o  out  1  victim selection strobe to the replacement policy.
- sel_victim_set_o  out  S  set under selection.
- sel_dir_valid_o, sel_dir_wback_o, sel_dir_dirty_o, sel_dir_fetch_o  out  W each  directory state forwarded to the policy.
- sel_victim_way_i  in  W  one-hot victim way from the policy, combinational on sel_*; all-zero means no way available.
- updt_o  out  1  policy update strobe.
- updt_set_o  out  S  set to update.
- updt_way_o  out  W  one-hot way to update.
- wb_valid_o  out  1  dirty-victim writeback request.
- wb_ready_i  in  1  writeback accepted.
- wb_set_o  out  S  writeback set.
- wb_way_o  out  W  writeback way, one-hot.
- rsp_valid_o  out  1  single-cycle victim response pulse.
- rsp_set_o  out  S  response set.
- rsp_way_o  out  W  response way, one-hot.
- retry_cnt_o  out  8  saturating count of selections that returned no way.

Function
REQ-004 SHALL implement an FSM with states IDLE, DIR_RD, SELECT, WBACK, RESP.
REQ-005 IDLE: req_ready_o=1; on req_valid_i, SHALL register req_set_i into set_q and go to DIR_RD; req_ready_o SHALL be 0 in every other state.
REQ-006 DIR_RD: dir_rd_o=1, dir_rd_set_o=set_q; SHALL go to SELECT unconditionally.
REQ-007 SELECT: sel_victim_o=1, sel_victim_set_o=set_q, sel_dir_*_o = dir_*_i unmodified, combinational.
REQ-008 SELECT with sel_victim_way_i==0: SHALL go back to DIR_RD and increment retry_cnt_o, saturating at 255.
REQ-009 SELECT with sel_victim_way_i!=0: SHALL register it into way_q; SHALL register dirty_q = |(sel_victim_way_i & dir_valid_i & dir_dirty_i).
REQ-010 SELECT exit: dirty_q=1 SHALL go to WBACK; dirty_q=0 SHALL go to RESP.
REQ-011 WBACK: wb_valid_o=1, wb_set_o=set_q, wb_way_o=way_q, all held stable until wb_ready_i=1.
REQ-012 WBACK: SHALL go to RESP in the cycle after wb_valid_o & wb_ready_i.
REQ-013 RESP: rsp_valid_o=1, rsp_set_o=set_q, rsp_way_o=way_q for exactly one cycle.
REQ-014 RESP: SHALL also drive updt_o=1, updt_set_o=set_q, updt_way_o=way_q in the same cycle, then go to IDLE.
REQ-015 Clean-victim latency: request handshake at cycle 0 -> rsp_valid_o at cycle 3; the next request can be accepted at cycle 4.
REQ-016 Dirty-victim latency: 3 + (number of WBACK cycles) to rsp_valid_o.
REQ-017 Strobes dir_rd_o, sel_victim_o, wb_valid_o, updt_o and rsp_valid_o SHALL be high only in their named state; otherwise 0.
REQ-018 Data outputs not qualified by an active strobe SHALL be 0.
REQ-019 A request is never dropped; unbounded retries are permitted (no timeout).
REQ-020 The block SHALL handle one request at a time; req_valid_i outside IDLE has no effect.

Reset
REQ-021 While rst_ni=0, asynchronously: state=IDLE, set_q=0, way_q=0, dirty_q=0, retry_cnt_o=0.
REQ-022 While rst_ni=0, req_ready_o SHALL be 1 and all other outputs 0.
REQ-023 Reset asserted mid-operation, including in WBACK with wb_valid_o high, SHALL abandon the request with no response and no update; wb_valid_o drops asynchronously.

Verification (SETS=64, WAYS=4)
REQ-024 Clean victim: req set=5; dir_valid=1111, dirty=0000; policy returns 0100 -> rsp_valid at cycle 3 with set 5, way 0100; updt_o same cycle; wb_valid never high.
REQ-025 Dirty victim: set=9; valid=1111, dirty=0010; policy returns 0010; wb_ready held low 4 cycles -> wb_valid stable with set 9, way 0010 for 5 cycles; rsp_valid 1 cycle after handshake.
REQ-026 No way available: fetch=1111 for 2 selections, then 0000 with policy returning 0001 -> retry_cnt_o=2; DIR_RD/SELECT repeated twice; rsp way 0001.
REQ-027 Saturation: force 300 consecutive empty selections -> retry_cnt_o stays 255.
REQ-028 Back-to-back: req_valid held high with sets 3 then 4 -> accepts at cycles 0 and 4; two rsp pulses at cycles 3 and 7.
REQ-029 Reset in WBACK: rst_ni low for 1 cycle -> outputs at reset values immediately; no rsp_valid or updt_o afterward; req_ready_o=1.
